// File: rtl/mic_fir_scheduler.sv
// Time-shares one decimating FIR across CHANNELS microphone channels: serialises each captured
// frame into the FIR, regathers the gained results and presents them as one parallel frame.
module mic_fir_scheduler #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned GAIN_SHIFT = 6,
    parameter int unsigned IDX_WIDTH  = $clog2(CHANNELS)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          s_valid,
    input  logic [CHANNELS*IN_WIDTH-1:0]  s_data,
    output logic                          s_ready,
    output logic                          fir_in_tvalid,
    input  logic                          fir_in_tready,
    output logic [IN_WIDTH-1:0]           fir_in_tdata,
    output logic [IDX_WIDTH-1:0]          fir_in_tuser,
    input  logic                          fir_out_tvalid,
    output logic                          fir_out_tready,
    input  logic [OUT_WIDTH-1:0]          fir_out_tdata,
    input  logic [IDX_WIDTH-1:0]          fir_out_tuser,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [CHANNELS*OUT_WIDTH-1:0] m_data,
    output logic                          overrun,
    output logic                          chan_err
);
    localparam int unsigned CntWidth  = $clog2(CHANNELS + 1);
    localparam int unsigned WideWidth = OUT_WIDTH + GAIN_SHIFT;
    localparam logic [CntWidth-1:0]  ChanCnt = CntWidth'(CHANNELS);
    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(CHANNELS - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOutput} state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   tx_idx_q, tx_idx_d;
    logic [CntWidth-1:0]    rx_idx_q, rx_idx_d;
    logic [IN_WIDTH-1:0]    frame_q [CHANNELS];
    logic [IN_WIDTH-1:0]    frame_d [CHANNELS];
    logic [OUT_WIDTH-1:0]   res_q [CHANNELS];
    logic [OUT_WIDTH-1:0]   res_d [CHANNELS];
    logic                   overrun_q, overrun_d;
    logic                   chan_err_q, chan_err_d;

    logic                   fir_in_hs;
    logic                   fir_out_hs;
    logic [IDX_WIDTH-1:0]   rx_lane;
    logic [WideWidth-1:0]   gain_wide;
    logic [GAIN_SHIFT:0]    gain_top;
    logic [OUT_WIDTH-1:0]   gain_sat;

    // Sign-extended shift is exact in WideWidth; saturate when the bits above the
    // output sign bit disagree.
    always_comb begin
        gain_wide = {{GAIN_SHIFT{fir_out_tdata[OUT_WIDTH-1]}}, fir_out_tdata} << GAIN_SHIFT;
        gain_top  = gain_wide[WideWidth-1:OUT_WIDTH-1];
        if ((&gain_top) || (~|gain_top)) begin
            gain_sat = gain_wide[OUT_WIDTH-1:0];
        end else if (gain_wide[WideWidth-1]) begin
            gain_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            gain_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        s_ready        = (state_q == StIdle);
        fir_in_tvalid  = (state_q == StIssue);
        fir_in_tdata   = frame_q[tx_idx_q];
        fir_in_tuser   = tx_idx_q;
        fir_out_tready = ((state_q == StIssue) || (state_q == StWait)) && (rx_idx_q < ChanCnt);
        m_valid        = (state_q == StOutput);
        overrun        = overrun_q;
        chan_err       = chan_err_q;
        m_data         = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            m_data[i*OUT_WIDTH +: OUT_WIDTH] = res_q[i];
        end
    end

    assign fir_in_hs  = fir_in_tvalid && fir_in_tready;
    assign fir_out_hs = fir_out_tvalid && fir_out_tready;
    assign rx_lane    = rx_idx_q[IDX_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        tx_idx_d   = tx_idx_q;
        rx_idx_d   = rx_idx_q;
        frame_d    = frame_q;
        res_d      = res_q;
        overrun_d  = s_valid && (state_q != StIdle);
        chan_err_d = 1'b0;

        // Results are stored by arrival order; a wrong echoed index only raises chan_err.
        if (fir_out_hs) begin
            res_d[rx_lane] = gain_sat;
            rx_idx_d       = rx_idx_q + CntWidth'(1);
            chan_err_d     = (fir_out_tuser != rx_lane);
        end

        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    for (int i = 0; i < int'(CHANNELS); i++) begin
                        frame_d[i] = s_data[i*IN_WIDTH +: IN_WIDTH];
                    end
                    tx_idx_d = '0;
                    rx_idx_d = '0;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (fir_in_hs) begin
                    tx_idx_d = tx_idx_q + IDX_WIDTH'(1);
                    if (tx_idx_q == LastIdx) begin
                        state_d = (rx_idx_d == ChanCnt) ? StOutput : StWait;
                    end
                end
            end
            StWait: begin
                // Look at the next count so m_valid rises right after the last result.
                if (rx_idx_d == ChanCnt) begin
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            tx_idx_q   <= '0;
            rx_idx_q   <= '0;
            overrun_q  <= 1'b0;
            chan_err_q <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                frame_q[i] <= '0;
                res_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            tx_idx_q   <= tx_idx_d;
            rx_idx_q   <= rx_idx_d;
            overrun_q  <= overrun_d;
            chan_err_q <= chan_err_d;
            frame_q    <= frame_d;
            res_q      <= res_d;
        end
    end

endmodule

// File: tb/tb_mic_fir_scheduler.sv
// Bench for mic_fir_scheduler: a queue-based ideal FIR (1-cycle echo, x>>8) and a
// plain-arithmetic gain/saturation reference check every gathered frame.
module tb_mic_fir_scheduler;
    localparam int CH = 4;
    localparam int IW = 24;
    localparam int OW = 16;
    localparam int XW = 2;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             s_valid = 1'b0;
    logic [CH*IW-1:0] s_data = '0;
    logic             s_ready;
    logic             fir_in_tvalid;
    logic             fir_in_tready = 1'b0;
    logic [IW-1:0]    fir_in_tdata;
    logic [XW-1:0]    fir_in_tuser;
    logic             fir_out_tvalid = 1'b0;
    logic             fir_out_tready;
    logic [OW-1:0]    fir_out_tdata = '0;
    logic [XW-1:0]    fir_out_tuser = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [CH*OW-1:0] m_data;
    logic             overrun;
    logic             chan_err;

    mic_fir_scheduler dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .fir_in_tvalid  (fir_in_tvalid),
        .fir_in_tready  (fir_in_tready),
        .fir_in_tdata   (fir_in_tdata),
        .fir_in_tuser   (fir_in_tuser),
        .fir_out_tvalid (fir_out_tvalid),
        .fir_out_tready (fir_out_tready),
        .fir_out_tdata  (fir_out_tdata),
        .fir_out_tuser  (fir_out_tuser),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .overrun        (overrun),
        .chan_err       (chan_err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [IW-1:0] d;
        logic [XW-1:0] u;
    } fir_item_t;

    fir_item_t fq[$];
    fir_item_t pushed;
    fir_item_t popped;
    int        hs_log[$];
    int        in_ctl = 1;        // 0 low, 1 high, 2 random
    bit        out_en = 1'b1;
    bit        out_rand = 1'b0;
    bit        corrupt_first = 1'b0;
    int        ovr_cnt = 0;
    int        cerr_cnt = 0;
    int        checks = 0;
    int        passed = 0;

    function automatic logic [OW-1:0] fir_model(input logic [IW-1:0] x);
        logic signed [IW-1:0] sx;
        logic signed [IW-1:0] sh;
        sx = x;
        sh = sx >>> 8;
        return sh[OW-1:0];
    endfunction

    function automatic logic [OW-1:0] gain_ref(input logic [OW-1:0] r);
        int v;
        v = int'($signed(r)) * 64;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return OW'(v);
    endfunction

    function automatic logic [CH*OW-1:0] frame_ref(input logic [CH*IW-1:0] d);
        logic [CH*OW-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[i*OW +: OW] = gain_ref(fir_model(d[i*IW +: IW]));
        return r;
    endfunction

    // FIR model: capture handshakes on the clock edge, present results on the falling edge.
    always @(posedge clk_in) begin
        if (fir_out_tvalid && fir_out_tready && fq.size() > 0) begin
            popped = fq.pop_front();
            corrupt_first = 1'b0;
        end
        if (fir_in_tvalid && fir_in_tready) begin
            pushed.d = fir_in_tdata;
            pushed.u = fir_in_tuser;
            fq.push_back(pushed);
            hs_log.push_back(int'(fir_in_tuser));
        end
    end

    always @(negedge clk_in) begin
        case (in_ctl)
            0: fir_in_tready = 1'b0;
            1: fir_in_tready = 1'b1;
            default: fir_in_tready = 1'($urandom_range(0, 1));
        endcase
        if (fq.size() > 0 && out_en && (!out_rand || $urandom_range(0, 1) == 1)) begin
            fir_out_tvalid = 1'b1;
            fir_out_tdata  = fir_model(fq[0].d);
            fir_out_tuser  = corrupt_first ? XW'(1) : fq[0].u;
        end else begin
            fir_out_tvalid = 1'b0;
        end
        if (overrun) ovr_cnt++;
        if (chan_err) cerr_cnt++;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic int seq_code();
        int s;
        s = 0;
        foreach (hs_log[i]) s = s * 10 + hs_log[i] + 1;
        return s;
    endfunction

    task automatic start_frame(input logic [CH*IW-1:0] d);
        int t;
        t = 0;
        while (!s_ready && t < 100) begin
            tick();
            t++;
        end
        hs_log.delete();
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic finish_frame(input logic [CH*OW-1:0] expd, input int delay,
                                input string name, output logic [CH*OW-1:0] got);
        int t;
        t = 0;
        while (!m_valid && t < 200) begin
            tick();
            t++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            $display("FAIL %s m_valid timeout: got %b want 1", name, m_valid);
            got = '0;
            return;
        end
        passed++;
        repeat (delay) tick();
        got = m_data;
        checks++;
        if (m_data !== expd) $display("FAIL %s m_data: got %h want %h", name, m_data, expd);
        else passed++;
        checks++;
        if (seq_code() !== 1234) $display("FAIL %s issue order: got %0d want 1234", name, seq_code());
        else passed++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic run_frame(input logic [CH*IW-1:0] d, input int delay, input string name,
                             output logic [CH*OW-1:0] got);
        start_frame(d);
        finish_frame(frame_ref(d), delay, name, got);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        tick();
        tick();
        checks++;
        if ({fir_in_tvalid, fir_in_tdata, fir_in_tuser, fir_out_tready, m_valid, m_data,
             overrun, chan_err} !== '0)
            $display("FAIL reset outputs: got tvalid=%b m_valid=%b m_data=%h tready=%b",
                     fir_in_tvalid, m_valid, m_data, fir_out_tready);
        else passed++;
        checks++;
        if (s_ready !== 1'b1) $display("FAIL reset s_ready: got %b want 1", s_ready);
        else passed++;
        #3 rst_in = 1'b1;
        tick();
        checks++;
        if (fir_in_tvalid !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL post-reset idle: got tvalid=%b s_ready=%b want 0/1", fir_in_tvalid, s_ready);
        else passed++;
    endtask

    task automatic test_directed();
        logic [CH*IW-1:0] d;
        logic [CH*OW-1:0] expd;
        d    = {24'h000000, 24'hFFFF00, 24'h000200, 24'h000100};
        expd = {16'd0, 16'hFFC0, 16'd128, 16'd64};
        in_ctl = 1;
        start_frame(d);
        for (int k = 0; k < CH; k++) begin
            checks++;
            if (fir_in_tvalid !== 1'b1 || fir_in_tuser !== XW'(k))
                $display("FAIL directed issue cycle %0d: got tvalid=%b tuser=%0d want 1/%0d",
                         k + 1, fir_in_tvalid, fir_in_tuser, k);
            else passed++;
            tick();
        end
        checks++;
        if (m_valid !== 1'b0 || fir_in_tvalid !== 1'b0)
            $display("FAIL directed wait: got m_valid=%b tvalid=%b want 0/0", m_valid, fir_in_tvalid);
        else passed++;
        tick();
        checks++;
        if (m_valid !== 1'b1) $display("FAIL directed m_valid latency: got %b want 1", m_valid);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== expd)
                $display("FAIL directed hold %0d: got m_valid=%b m_data=%h want 1/%h",
                         k, m_valid, m_data, expd);
            else passed++;
            tick();
        end
        checks++;
        if (seq_code() !== 1234) $display("FAIL directed order: got %0d want 1234", seq_code());
        else passed++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL directed release: got m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [CH*IW-1:0] d;
        logic [CH*OW-1:0] got;
        int t;
        for (int i = 0; i < CH; i++) d[i*IW +: IW] = IW'($urandom);
        in_ctl = 1;
        start_frame(d);
        t = 0;
        while (!(fir_in_tvalid && fir_in_tuser == XW'(2)) && t < 50) begin
            tick();
            t++;
        end
        in_ctl = 0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (fir_in_tvalid !== 1'b1 || fir_in_tuser !== XW'(2) || fir_in_tdata !== d[2*IW +: IW])
                $display("FAIL backpressure stall %0d: got tvalid=%b tuser=%0d tdata=%h want 1/2/%h",
                         k, fir_in_tvalid, fir_in_tuser, fir_in_tdata, d[2*IW +: IW]);
            else passed++;
            tick();
        end
        in_ctl = 1;
        finish_frame(frame_ref(d), 1, "backpressure", got);
    endtask

    task automatic test_saturation();
        logic [CH*IW-1:0] d;
        logic [CH*OW-1:0] got;
        d = {24'h123456, 24'hFE0180, 24'hFC0000, 24'h020000};
        run_frame(d, 0, "saturation", got);
        checks++;
        if (got[0 +: OW] !== 16'h7FFF || got[OW +: OW] !== 16'h8000)
            $display("FAIL saturation lanes: got %h/%h want 7fff/8000", got[0 +: OW], got[OW +: OW]);
        else passed++;
    endtask

    task automatic test_overrun();
        logic [CH*IW-1:0] d;
        logic [CH*OW-1:0] got;
        int t;
        for (int i = 0; i < CH; i++) d[i*IW +: IW] = IW'($urandom);
        ovr_cnt = 0;
        out_en  = 1'b0;
        start_frame(d);
        t = 0;
        while (hs_log.size() < CH && t < 50) begin
            tick();
            t++;
        end
        checks++;
        if (fir_in_tvalid !== 1'b0 || m_valid !== 1'b0)
            $display("FAIL overrun reach wait: got tvalid=%b m_valid=%b want 0/0", fir_in_tvalid, m_valid);
        else passed++;
        s_data  = ~d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) $display("FAIL overrun in wait: got %b want 1", overrun);
        else passed++;
        tick();
        checks++;
        if (overrun !== 1'b0) $display("FAIL overrun pulse width: got %b want 0", overrun);
        else passed++;
        out_en = 1'b1;
        t = 0;
        while (!m_valid && t < 50) begin
            tick();
            t++;
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== frame_ref(d))
            $display("FAIL overrun first frame: got m_valid=%b m_data=%h want 1/%h",
                     m_valid, m_data, frame_ref(d));
        else passed++;
        s_data  = {d[IW-1:0], d[CH*IW-1:IW]};
        s_valid = 1'b1;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (overrun !== 1'b1 || m_valid !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL overrun at handshake: got overrun=%b m_valid=%b s_ready=%b want 1/0/1",
                     overrun, m_valid, s_ready);
        else passed++;
        tick();
        tick();
        checks++;
        if (fir_in_tvalid !== 1'b0 || s_ready !== 1'b1 || ovr_cnt !== 2)
            $display("FAIL overrun drop: got tvalid=%b s_ready=%b pulses=%0d want 0/1/2",
                     fir_in_tvalid, s_ready, ovr_cnt);
        else passed++;
        got = '0;
    endtask

    task automatic test_chan_err();
        logic [CH*IW-1:0] d;
        logic [CH*OW-1:0] got;
        for (int i = 0; i < CH; i++) d[i*IW +: IW] = IW'($urandom);
        cerr_cnt      = 0;
        corrupt_first = 1'b1;
        run_frame(d, 0, "chan_err", got);
        tick();
        checks++;
        if (cerr_cnt !== 1) $display("FAIL chan_err pulses: got %0d want 1", cerr_cnt);
        else passed++;
        checks++;
        if (got[0 +: OW] !== gain_ref(fir_model(d[0 +: IW])))
            $display("FAIL chan_err lane0: got %h want %h", got[0 +: OW], gain_ref(fir_model(d[0 +: IW])));
        else passed++;
    endtask

    task automatic test_async_reset();
        logic [CH*IW-1:0] d;
        logic [CH*OW-1:0] got;
        int t;
        for (int i = 0; i < CH; i++) d[i*IW +: IW] = IW'($urandom);
        in_ctl = 1;
        start_frame(d);
        t = 0;
        while (hs_log.size() < 2 && t < 50) begin
            tick();
            t++;
        end
        #2;
        rst_in = 1'b0;
        fq.delete();
        #1;
        checks++;
        if ({fir_in_tvalid, fir_in_tdata, fir_in_tuser, fir_out_tready, m_valid, m_data,
             overrun, chan_err} !== '0)
            $display("FAIL async reset outputs: got tvalid=%b tuser=%0d tdata=%h tready=%b m_data=%h",
                     fir_in_tvalid, fir_in_tuser, fir_in_tdata, fir_out_tready, m_data);
        else passed++;
        tick();
        #3 rst_in = 1'b1;
        tick();
        for (int i = 0; i < CH; i++) d[i*IW +: IW] = IW'($urandom);
        run_frame(d, 0, "after reset", got);
    endtask

    task automatic test_random();
        logic [CH*IW-1:0] d;
        logic [CH*OW-1:0] got;
        ovr_cnt  = 0;
        cerr_cnt = 0;
        in_ctl   = 2;
        out_rand = 1'b1;
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < CH; i++) begin
                d[i*IW +: IW] = IW'($urandom);
                if ($urandom_range(0, 3) == 0) d[i*IW +: IW] = {IW{1'b0}} | IW'($urandom_range(0, 1) << 23);
            end
            run_frame(d, int'($urandom_range(0, 3)), "random", got);
        end
        in_ctl   = 1;
        out_rand = 1'b0;
        tick();
        checks++;
        if (ovr_cnt !== 0 || cerr_cnt !== 0)
            $display("FAIL random spurious pulses: got overrun=%0d chan_err=%0d want 0/0", ovr_cnt, cerr_cnt);
        else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_saturation();
        test_overrun();
        test_chan_err();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
